hs_elastic_buffer: RTL and testbench

Elastic FIFO stage that sits directly downstream of a dataflow graph's `out` port, between `dout_*` and the consumer.
- Upstream it behaves as a consumer: drives req, captures ack+data.
- Downstream it behaves as a producer: receives req, returns a one-cycle ack with data.
- Purpose: decouple graph throughput from consumer stalls and absorb bursts without losing items.

---
 rtl/hs_elastic_buffer_pkg.sv | 25 ++
 rtl/hs_fifo_mem.sv | 34 +++
 rtl/hs_elastic_buffer.sv | 99 +++++++++
 tb/tb_hs_elastic_buffer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_elastic_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hs_elastic_buffer_pkg
// Description : Shared constants and helpers for the handshake elastic buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package hs_elastic_buffer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int ACK_PULSE_LEN      = 1;
    localparam int REQ_SLACK          = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hs_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : hs_fifo_mem
// Description : DEPTH x DATA_WIDTH register array, synchronous write and
//               asynchronous read. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_fifo_mem
    import hs_elastic_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int AW         = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/hs_elastic_buffer.sv
`default_nettype none
// ============================================================================
// Module      : hs_elastic_buffer
// Description : Elastic FIFO stage between a dataflow graph output (req/ack
//               consumer side) and a downstream consumer (req/ack producer).
// Revision    : 1.0 - initial release
// ============================================================================
module hs_elastic_buffer
    import hs_elastic_buffer_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int DEPTH      = 4,
    localparam int AW         = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  up_req,
    input  logic                  up_ack,
    input  logic [DATA_WIDTH-1:0] up_din,
    input  logic                  dn_req,
    output logic                  dn_ack,
    output logic [DATA_WIDTH-1:0] dn_dout,
    output logic [AW:0]           count,
    output logic                  overflow_err
);

    localparam logic [AW:0] c_full       = (AW + 1)'(DEPTH);
    // Upstream samples req one edge late, so keep REQ_SLACK slots free for its last ack.
    localparam logic [AW:0] c_req_thresh = (AW + 1)'(DEPTH - 1 - REQ_SLACK);

    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  r_up_req;
    logic                  r_dn_ack;
    logic [DATA_WIDTH-1:0] r_dn_dout;
    logic                  r_overflow_err;

    logic                  w_full;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_drop;
    logic [AW:0]           w_count_next;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_full       = (r_count == c_full);
    assign w_rd         = dn_req & ~r_dn_ack & (r_count != '0);
    // A full buffer still accepts an item on an edge that also reads one out.
    assign w_wr         = up_ack & ~(w_full & ~w_rd);
    assign w_drop       = up_ack & w_full & ~w_rd;
    assign w_count_next = r_count + (AW + 1)'(w_wr) - (AW + 1)'(w_rd);

    hs_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_wr),
        .waddr (r_wr_ptr),
        .wdata (up_din),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_up_req       <= 1'b0;
            r_dn_ack       <= 1'b0;
            r_dn_dout      <= '0;
            r_overflow_err <= 1'b0;
        end else begin
            r_count  <= w_count_next;
            r_up_req <= (w_count_next <= c_req_thresh);
            r_dn_ack <= w_rd;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_dn_dout <= w_rdata;
            end
            if (w_drop) begin
                r_overflow_err <= 1'b1;
            end
        end
    end

    assign up_req       = r_up_req;
    assign dn_ack       = r_dn_ack;
    assign dn_dout      = r_dn_dout;
    assign count        = r_count;
    assign overflow_err = r_overflow_err;

endmodule
`default_nettype wire

// File: tb/tb_hs_elastic_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hs_elastic_buffer
// Description : Directed vector table plus multi-cycle sequences for
//               hs_elastic_buffer (DEPTH=4, DATA_WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_elastic_buffer;

    logic        clk;
    logic        rst;
    logic        up_req;
    logic        up_ack;
    logic [31:0] up_din;
    logic        dn_req;
    logic        dn_ack;
    logic [31:0] dn_dout;
    logic [2:0]  count;
    logic        overflow_err;

    hs_elastic_buffer #(
        .DATA_WIDTH (32),
        .DEPTH      (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .up_req       (up_req),
        .up_ack       (up_ack),
        .up_din       (up_din),
        .dn_req       (dn_req),
        .dn_ack       (dn_ack),
        .dn_dout      (dn_dout),
        .count        (count),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        up_ack;
        logic [31:0] up_din;
        logic        dn_req;
        logic        e_up_req;
        logic        e_dn_ack;
        logic [31:0] e_dout;
        logic [2:0]  e_count;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_pass;
    int   n_total;
    int   prod_val;

    task automatic add(input logic r, input logic ack, input logic [31:0] din,
                       input logic req, input logic eur, input logic eda,
                       input logic [31:0] edo, input logic [2:0] ec, input logic eo);
        vec_t v;
        v.rst = r;       v.up_ack = ack;   v.up_din = din;  v.dn_req = req;
        v.e_up_req = eur; v.e_dn_ack = eda; v.e_dout = edo;
        v.e_count = ec;  v.e_ovf = eo;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Upstream model: acks one cycle after seeing req, never back-to-back.
    task automatic prod_step(input bit en);
        if (en && up_req && !up_ack) begin
            up_ack   = 1'b1;
            up_din   = prod_val;
            prod_val = prod_val + 1;
        end else begin
            up_ack = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        up_ack = 1'b0;
        dn_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int exp_val;
        int max_cnt;
        int n_rx;
        int last_c;

        n_pass   = 0;
        n_total  = 0;
        prod_val = 0;
        rst      = 1'b1;
        up_ack   = 1'b0;
        up_din   = '0;
        dn_req   = 1'b1;

        //   rst ack din       req  ureq dack dout      cnt ovf
        add(1, 0, 32'h0,   1,   0,   0,   32'h0,   0,  0);
        add(1, 0, 32'h0,   1,   0,   0,   32'h0,   0,  0);
        add(1, 0, 32'h0,   1,   0,   0,   32'h0,   0,  0);
        add(0, 0, 32'h0,   1,   1,   0,   32'h0,   0,  0);
        add(0, 1, 32'hA0,  0,   1,   0,   32'h0,   1,  0);
        add(0, 1, 32'hA1,  0,   1,   0,   32'h0,   2,  0);
        add(0, 1, 32'hA2,  0,   0,   0,   32'h0,   3,  0);
        add(0, 1, 32'hA3,  0,   0,   0,   32'h0,   4,  0);
        add(0, 0, 32'h0,   1,   0,   1,   32'hA0,  3,  0);
        add(0, 0, 32'h0,   1,   0,   0,   32'hA0,  3,  0);
        add(0, 0, 32'h0,   1,   1,   1,   32'hA1,  2,  0);
        add(0, 0, 32'h0,   0,   1,   0,   32'hA1,  2,  0);
        add(0, 1, 32'hA4,  1,   1,   1,   32'hA2,  2,  0);
        add(0, 0, 32'h0,   1,   1,   0,   32'hA2,  2,  0);
        add(0, 0, 32'h0,   1,   1,   1,   32'hA3,  1,  0);
        add(0, 0, 32'h0,   1,   1,   0,   32'hA3,  1,  0);
        add(0, 0, 32'h0,   1,   1,   1,   32'hA4,  0,  0);
        add(0, 0, 32'h0,   1,   1,   0,   32'hA4,  0,  0);
        add(0, 0, 32'h0,   1,   1,   0,   32'hA4,  0,  0);
        add(0, 1, 32'hB0,  0,   1,   0,   32'hA4,  1,  0);
        add(0, 1, 32'hB1,  0,   1,   0,   32'hA4,  2,  0);
        add(0, 1, 32'hB2,  0,   0,   0,   32'hA4,  3,  0);
        add(0, 1, 32'hB3,  0,   0,   0,   32'hA4,  4,  0);
        add(0, 1, 32'hB4,  0,   0,   0,   32'hA4,  4,  1);
        add(0, 0, 32'h0,   1,   0,   1,   32'hB0,  3,  1);
        add(0, 1, 32'hB5,  1,   0,   0,   32'hB0,  4,  1);
        add(0, 1, 32'hB6,  1,   0,   1,   32'hB1,  4,  1);
        add(0, 0, 32'h0,   1,   0,   0,   32'hB1,  4,  1);
        add(0, 0, 32'h0,   1,   0,   1,   32'hB2,  3,  1);
        add(1, 0, 32'h0,   0,   0,   0,   32'h0,   0,  0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst    = vecs[i].rst;
            up_ack = vecs[i].up_ack;
            up_din = vecs[i].up_din;
            dn_req = vecs[i].dn_req;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_up_req", i), up_req, vecs[i].e_up_req);
            check($sformatf("vec%0d_dn_ack", i), dn_ack, vecs[i].e_dn_ack);
            check($sformatf("vec%0d_dn_dout", i), dn_dout, vecs[i].e_dout);
            check($sformatf("vec%0d_count", i), count, vecs[i].e_count);
            check($sformatf("vec%0d_ovf", i), overflow_err, vecs[i].e_ovf);
        end

        // Passthrough: 200 items through an always-requesting consumer.
        do_reset();
        prod_val = 0;
        exp_val  = 0;
        max_cnt  = 0;
        dn_req   = 1'b1;
        for (int c = 0; c < 3000 && exp_val < 200; c++) begin
            @(posedge clk);
            #1;
            if (dn_ack) begin
                check("pass_data", dn_dout, exp_val);
                exp_val++;
            end
            if (int'(count) > max_cnt) max_cnt = int'(count);
            prod_step(1'b1);
        end
        check("pass_items", exp_val, 200);
        check("pass_count_le2", (max_cnt <= 2), 1);
        check("pass_ovf", overflow_err, 0);

        // Backpressure fill then drain.
        do_reset();
        prod_val = 0;
        max_cnt  = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (int'(count) > max_cnt) max_cnt = int'(count);
            prod_step(1'b1);
        end
        check("bp_up_req_low", up_req, 0);
        check("bp_count_3or4", (count == 3 || count == 4), 1);
        check("bp_count_le4", (max_cnt <= 4), 1);
        check("bp_ovf", overflow_err, 0);
        dn_req = 1'b1;
        n_rx   = 0;
        last_c = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (dn_ack) begin
                check("bp_data", dn_dout, n_rx);
                if (n_rx > 0) check("bp_ack_gap", c - last_c, 2);
                last_c = c;
                n_rx++;
            end
            prod_step(1'b0);
        end
        check("bp_items", n_rx, 3);
        check("bp_count_empty", count, 0);
        check("bp_up_req_back", up_req, 1);

        // Reset mid-operation discards held items.
        do_reset();
        up_ack = 1'b1;
        for (int k = 10; k <= 12; k++) begin
            up_din = k;
            @(posedge clk);
            #1;
        end
        up_ack = 1'b0;
        check("mid_count3", count, 3);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_dn_ack", dn_ack, 0);
        rst      = 1'b0;
        prod_val = 0;
        dn_req   = 1'b1;
        n_rx     = 0;
        for (int c = 0; c < 100 && n_rx < 3; c++) begin
            @(posedge clk);
            #1;
            if (dn_ack) begin
                check("mid_data", dn_dout, n_rx);
                n_rx++;
            end
            prod_step(1'b1);
        end
        check("mid_items", n_rx, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
